thresh_mon: RTL and testbench

Parametrised N-channel measurement monitor for the Segway's slow analog channels: battery, load cells and steering pot. It generalises the single fixed battery-low compare into per-channel IIR averaging, a selectable under/over threshold, hysteresis and sample-count debounce. It sits between A2D_intf-style sample producers and consumers such as piezo_drv and the balance/steer logic. It emits registered per-channel alarm flags and a change-event pulse.

---
 rtl/thresh_mon.sv | 180 ++++++++++++++++++
 tb/tb_thresh_mon.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thresh_mon.sv
// N-channel threshold monitor: per-channel IIR average, under/over compare with
// hysteresis and sample-count debounce. One shared datapath serves the addressed channel.
module thresh_mon #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 12,
  parameter int AVG_SHIFT = 2,
  parameter int DEB_CNT = 3,
  parameter logic [WIDTH-1:0] HYST = WIDTH'('h020),
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    smpl_vld,
  input  logic [CHW-1:0]          smpl_ch,
  input  logic [WIDTH-1:0]        smpl,
  input  logic [NUM_CH*WIDTH-1:0] thres,
  input  logic [NUM_CH-1:0]       mode,
  output logic [NUM_CH*WIDTH-1:0] avg,
  output logic [NUM_CH-1:0]       flag,
  output logic                    any_flag,
  output logic                    flag_chg,
  output logic [CHW-1:0]          flag_ch
);
  localparam int CW = $clog2(DEB_CNT + 1);

  logic [WIDTH-1:0]  avg_q [NUM_CH];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] primed_q;
  logic              any_flag_q;
  logic              flag_chg_q;
  logic [CHW-1:0]    flag_ch_q;

  logic              accept;
  logic [WIDTH-1:0]  avg_sel;
  logic [WIDTH-1:0]  thres_sel;
  logic              mode_sel;
  logic              flag_sel;
  logic              primed_sel;
  logic [CW-1:0]     cnt_sel;

  // Out-of-range channel indices are possible when NUM_CH is not a power of two.
  assign accept = smpl_vld && ({1'b0, smpl_ch} < (CHW+1)'(NUM_CH));

  always_comb begin
    avg_sel    = '0;
    thres_sel  = '0;
    mode_sel   = 1'b0;
    flag_sel   = 1'b0;
    primed_sel = 1'b0;
    cnt_sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (smpl_ch == CHW'(i)) begin
        avg_sel    = avg_q[i];
        thres_sel  = thres[i*WIDTH +: WIDTH];
        mode_sel   = mode[i];
        flag_sel   = flag_q[i];
        primed_sel = primed_q[i];
        cnt_sel    = cnt_q[i];
      end
    end
  end

  // The filtered value always lies between avg and smpl, so modular add is exact.
  logic signed [WIDTH+1:0] diff;
  logic signed [WIDTH+1:0] step;
  logic [WIDTH-1:0]        avg_nxt;

  assign diff    = $signed({2'b00, smpl}) - $signed({2'b00, avg_sel});
  assign step    = diff >>> AVG_SHIFT;
  assign avg_nxt = avg_sel + WIDTH'(step);

  logic [WIDTH:0] avg_x;
  logic [WIDTH:0] thr_x;
  logic [WIDTH:0] hyst_x;
  logic           set_c;
  logic           clr_c;
  logic           qual;

  assign avg_x  = {1'b0, avg_nxt};
  assign thr_x  = {1'b0, thres_sel};
  assign hyst_x = {1'b0, HYST};

  always_comb begin
    set_c = 1'b0;
    clr_c = 1'b0;
    if (mode_sel) begin
      set_c = avg_x > thr_x;
      clr_c = (avg_x + hyst_x) <= thr_x;
    end else begin
      set_c = avg_x < thr_x;
      clr_c = avg_x >= (thr_x + hyst_x);
    end
  end

  assign qual = flag_sel ? clr_c : set_c;

  logic [CW:0]       cnt_inc;
  logic [CW-1:0]     cnt_nxt;
  logic              flag_nxt;
  logic [WIDTH-1:0]  avg_wr;
  logic              toggle;
  logic [NUM_CH-1:0] flag_d;

  assign cnt_inc = {1'b0, cnt_sel} + (CW+1)'(1);

  // An unprimed channel only loads its average; the counter stays at zero.
  always_comb begin
    cnt_nxt  = '0;
    flag_nxt = flag_sel;
    if (primed_sel && qual) begin
      if (cnt_inc == (CW+1)'(DEB_CNT)) begin
        flag_nxt = ~flag_sel;
      end else begin
        cnt_nxt = cnt_inc[CW-1:0];
      end
    end
  end

  assign avg_wr = primed_sel ? avg_nxt : smpl;
  assign toggle = accept && (flag_nxt != flag_sel);

  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && (smpl_ch == CHW'(i))) begin
        flag_d[i] = flag_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        avg_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      flag_q     <= '0;
      primed_q   <= '0;
      any_flag_q <= 1'b0;
      flag_chg_q <= 1'b0;
      flag_ch_q  <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        avg_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      flag_q     <= '0;
      primed_q   <= '0;
      any_flag_q <= 1'b0;
      flag_chg_q <= 1'b0;
      flag_ch_q  <= '0;
    end else begin
      flag_q     <= flag_d;
      any_flag_q <= |flag_d;
      flag_chg_q <= toggle;
      if (toggle) begin
        flag_ch_q <= smpl_ch;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && (smpl_ch == CHW'(i))) begin
          avg_q[i]    <= avg_wr;
          cnt_q[i]    <= cnt_nxt;
          primed_q[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_avg_out
    assign avg[gi*WIDTH +: WIDTH] = avg_q[gi];
  end

  assign flag     = flag_q;
  assign any_flag = any_flag_q;
  assign flag_chg = flag_chg_q;
  assign flag_ch  = flag_ch_q;

endmodule

// File: tb/tb_thresh_mon.sv
// Bench for thresh_mon: two instances (4ch/shift2 and 3ch/shift0) checked against
// an integer reference model through an expected-value queue.
module tb_thresh_mon;
  localparam int HY  = 32;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a = 1'b0, vld_a = 1'b0;
  logic [1:0]  ch_a = '0;
  logic [11:0] smpl_a = '0;
  logic [47:0] thres_a = '0;
  logic [3:0]  mode_a = '0;
  logic [47:0] avg_a;
  logic [3:0]  flag_a;
  logic        any_a, chg_a;
  logic [1:0]  fch_a;

  logic        clr_b = 1'b0, vld_b = 1'b0;
  logic [1:0]  ch_b = '0;
  logic [11:0] smpl_b = '0;
  logic [35:0] thres_b = '0;
  logic [2:0]  mode_b = '0;
  logic [35:0] avg_b;
  logic [2:0]  flag_b;
  logic        any_b, chg_b;
  logic [1:0]  fch_b;

  thresh_mon #(.NUM_CH(4), .WIDTH(12), .AVG_SHIFT(2), .DEB_CNT(3), .HYST(12'h020)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .smpl_vld(vld_a), .smpl_ch(ch_a), .smpl(smpl_a),
    .thres(thres_a), .mode(mode_a), .avg(avg_a), .flag(flag_a), .any_flag(any_a),
    .flag_chg(chg_a), .flag_ch(fch_a)
  );

  thresh_mon #(.NUM_CH(3), .WIDTH(12), .AVG_SHIFT(0), .DEB_CNT(3), .HYST(12'h020)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .smpl_vld(vld_b), .smpl_ch(ch_b), .smpl(smpl_b),
    .thres(thres_b), .mode(mode_b), .avg(avg_b), .flag(flag_b), .any_flag(any_b),
    .flag_chg(chg_b), .flag_ch(fch_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_v;

  int m_avg [2][4];
  int m_cnt [2][4];
  bit m_fl  [2][4];
  bit m_pr  [2][4];
  bit m_chg [2];
  int m_ch  [2];

  function automatic logic [63:0] obs_a();
    return {8'h00, avg_a, flag_a, any_a, chg_a, fch_a};
  endfunction

  function automatic logic [63:0] obs_b();
    return {8'h00, 12'h000, avg_b, 1'b0, flag_b, any_b, chg_b, fch_b};
  endfunction

  task automatic model_reset(input int u);
    for (int i = 0; i < 4; i++) begin
      m_avg[u][i] = 0; m_cnt[u][i] = 0; m_fl[u][i] = 0; m_pr[u][i] = 0;
    end
    m_chg[u] = 0;
    m_ch[u] = 0;
  endtask

  // Drive one cycle on instance u, advance the model, queue the expected outputs.
  task automatic step(input int u, input bit vld, input int ch, input int s, input bit c);
    int nc, sh, d, q, a, t;
    bit md, setc, clrc, qual, anyf;
    logic [63:0] e;
    nc = (u == 0) ? 4 : 3;
    sh = (u == 0) ? 2 : 0;
    @(negedge clk);
    if (u == 0) begin
      vld_a = vld; ch_a = ch[1:0]; smpl_a = s[11:0]; clr_a = c;
    end else begin
      vld_b = vld; ch_b = ch[1:0]; smpl_b = s[11:0]; clr_b = c;
    end
    m_chg[u] = 0;
    if (c) begin
      model_reset(u);
    end else if (vld && ch < nc) begin
      if (!m_pr[u][ch]) begin
        m_avg[u][ch] = s;
        m_pr[u][ch] = 1;
      end else begin
        d = s - m_avg[u][ch];
        if (d >= 0) q = d / (1 << sh);
        else q = -((-d + (1 << sh) - 1) / (1 << sh));
        a = m_avg[u][ch] + q;
        m_avg[u][ch] = a;
        t = (u == 0) ? int'(thres_a[ch*12 +: 12]) : int'(thres_b[ch*12 +: 12]);
        md = (u == 0) ? mode_a[ch] : mode_b[ch];
        setc = md ? (a > t) : (a < t);
        clrc = md ? (a + HY <= t) : (a >= t + HY);
        qual = m_fl[u][ch] ? clrc : setc;
        if (qual) begin
          m_cnt[u][ch]++;
          if (m_cnt[u][ch] == DEB) begin
            m_cnt[u][ch] = 0;
            m_fl[u][ch] = !m_fl[u][ch];
            m_chg[u] = 1;
            m_ch[u] = ch;
          end
        end else begin
          m_cnt[u][ch] = 0;
        end
      end
    end
    e = '0;
    anyf = 0;
    for (int i = 0; i < nc; i++) begin
      e[8 + i*12 +: 12] = 12'(m_avg[u][i]);
      e[4 + i] = m_fl[u][i];
      anyf |= m_fl[u][i];
    end
    e[3] = anyf;
    e[2] = m_chg[u];
    e[1:0] = 2'(m_ch[u]);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    vld_a = 0; clr_a = 0; vld_b = 0; clr_b = 0;
  endtask

  task automatic test_reset();
    int seq[4] = '{'h300, 'h300, 'h300, 'h300};
    rst_n = 0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_a() !== 64'h0) begin n_err++; $display("FAIL reset_a got=%h exp=0", obs_a()); end
    n_cmp++;
    if (obs_b() !== 64'h0) begin n_err++; $display("FAIL reset_b got=%h exp=0", obs_b()); end
    @(negedge clk);
    rst_n = 1;
    thres_a = {12'h000, 12'h000, 12'h400, 12'h000};
    mode_a = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, seq[i], 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_a() !== exp_v) begin n_err++; $display("FAIL reset_pre[%0d] got=%h exp=%h", i, obs_a(), exp_v); end
      $display("reset_pre[%0d] ch1 smpl=%h avg1=%h flag=%b", i, seq[i], avg_a[23:12], flag_a);
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs_a() !== 64'h0) begin n_err++; $display("FAIL reset_async got=%h exp=0", obs_a()); end
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 1, 'h123, 0);
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (obs_a() !== exp_v) begin n_err++; $display("FAIL reset_prime got=%h exp=%h", obs_a(), exp_v); end
    n_cmp++;
    if (avg_a[23:12] !== 12'h123 || flag_a !== 4'b0000) begin
      n_err++; $display("FAIL reset_prime_val avg1=%h flag=%b exp avg1=123 flag=0000", avg_a[23:12], flag_a);
    end
    $display("reset_prime ch1 smpl=123 avg1=%h flag=%b", avg_a[23:12], flag_a);
  endtask

  task automatic test_under_debounce();
    int seq[6]  = '{'h900, 'h700, 'h700, 'h700, 'h700, 'h700};
    int avgs[6] = '{'h900, 'h880, 'h820, 'h7D8, 'h7A2, 'h779};
    logic [11:0] ea;
    thres_a[35:24] = 12'h800;
    mode_a[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2, seq[i], 0);
      exp_v = sb_q.pop_front();
      ea = 12'(avgs[i]);
      n_cmp++;
      if (obs_a() !== exp_v) begin n_err++; $display("FAIL under_sb[%0d] got=%h exp=%h", i, obs_a(), exp_v); end
      n_cmp++;
      if (avg_a[35:24] !== ea || flag_a[2] !== (i == 5)) begin
        n_err++; $display("FAIL under_avg[%0d] avg2=%h flag2=%b exp avg2=%h flag2=%b", i, avg_a[35:24], flag_a[2], ea, (i == 5));
      end
      $display("under[%0d] smpl=%h avg2=%h flag=%b chg=%b ch=%0d", i, seq[i], avg_a[35:24], flag_a, chg_a, fch_a);
    end
    n_cmp++;
    if ({chg_a, fch_a, any_a} !== 4'b1101) begin
      n_err++; $display("FAIL under_event chg/ch/any=%b%b%b exp=1/10/1", chg_a, fch_a, any_a);
    end
    step(0, 0, 0, 0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (obs_a() !== exp_v || chg_a !== 1'b0) begin n_err++; $display("FAIL under_pulse got=%h exp=%h", obs_a(), exp_v); end
    $display("under_idle chg=%b any=%b", chg_a, any_a);
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 2, 'h810, 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_a() !== exp_v) begin n_err++; $display("FAIL hyst_band[%0d] got=%h exp=%h", i, obs_a(), exp_v); end
      $display("hyst_band[%0d] smpl=810 avg2=%h flag=%b", i, avg_a[35:24], flag_a);
    end
    n_cmp++;
    if (flag_a[2] !== 1'b1 || avg_a[35:24] >= 12'h820) begin
      n_err++; $display("FAIL hyst_hold flag2=%b avg2=%h exp flag2=1 avg2<820", flag_a[2], avg_a[35:24]);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2, 'hA00, 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_a() !== exp_v) begin n_err++; $display("FAIL hyst_rise[%0d] got=%h exp=%h", i, obs_a(), exp_v); end
      n_cmp++;
      if (flag_a[2] !== (i != 2) || chg_a !== (i == 2)) begin
        n_err++; $display("FAIL hyst_clear[%0d] flag2=%b chg=%b exp flag2=%b chg=%b", i, flag_a[2], chg_a, (i != 2), (i == 2));
      end
      $display("hyst_rise[%0d] smpl=A00 avg2=%h flag=%b chg=%b", i, avg_a[35:24], flag_a, chg_a);
    end
  endtask

  task automatic test_debounce_interrupt();
    int seq[6] = '{'h200, 'h200, 'h050, 'h200, 'h200, 'h200};
    thres_b[11:0] = 12'h100;
    mode_b[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, seq[i], 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_b() !== exp_v) begin n_err++; $display("FAIL deb_sb[%0d] got=%h exp=%h", i, obs_b(), exp_v); end
      n_cmp++;
      if (flag_b[0] !== (i == 5)) begin
        n_err++; $display("FAIL deb_flag[%0d] flag0=%b exp=%b", i, flag_b[0], (i == 5));
      end
      $display("deb[%0d] ch0 smpl=%h avg0=%h flag=%b", i, seq[i], avg_b[11:0], flag_b);
    end
  endtask

  task automatic test_channels();
    int chs[9]  = '{1, 0, 3, 1, 0, 1, 3, 0, 1};
    int smps[9] = '{'h300, 'h050, 'hFFF, 'h300, 'h050, 'h300, 'hFFF, 'h050, 'h300};
    thres_b[23:12] = 12'h400;
    mode_b[1] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1, 1, chs[i], smps[i], 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_b() !== exp_v) begin n_err++; $display("FAIL chan_sb[%0d] got=%h exp=%h", i, obs_b(), exp_v); end
      $display("chan[%0d] ch=%0d smpl=%h flag=%b chg=%b fch=%0d", i, chs[i], smps[i], flag_b, chg_b, fch_b);
    end
    n_cmp++;
    if ({flag_b, chg_b, fch_b, avg_b[35:24]} !== {3'b010, 1'b1, 2'd1, 12'h000}) begin
      n_err++; $display("FAIL chan_final flag=%b chg=%b fch=%0d avg2=%h exp flag=010 chg=1 fch=1 avg2=000", flag_b, chg_b, fch_b, avg_b[35:24]);
    end
  endtask

  task automatic test_clr();
    thres_a[11:0] = 12'h800;
    mode_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 'h100, 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_a() !== exp_v) begin n_err++; $display("FAIL clr_pre[%0d] got=%h exp=%h", i, obs_a(), exp_v); end
      $display("clr_pre[%0d] ch0 smpl=100 avg0=%h flag=%b", i, avg_a[11:0], flag_a);
    end
    step(0, 1, 0, 'h100, 1);
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (obs_a() !== 64'h0 || exp_v !== 64'h0) begin n_err++; $display("FAIL clr_state got=%h exp=0", obs_a()); end
    $display("clr_hit avg=%h flag=%b", avg_a, flag_a);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 'h100, 0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs_a() !== exp_v) begin n_err++; $display("FAIL clr_post[%0d] got=%h exp=%h", i, obs_a(), exp_v); end
      n_cmp++;
      if (flag_a[0] !== (i == 3) || avg_a[11:0] !== 12'h100) begin
        n_err++; $display("FAIL clr_reprime[%0d] flag0=%b avg0=%h exp flag0=%b avg0=100", i, flag_a[0], avg_a[11:0], (i == 3));
      end
      $display("clr_post[%0d] ch0 smpl=100 avg0=%h flag=%b", i, avg_a[11:0], flag_a);
    end
  endtask

  initial begin
    test_reset();
    test_under_debounce();
    test_hysteresis();
    test_debounce_interrupt();
    test_channels();
    test_clr();
    n_cmp++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
